// File: rtl/ifetch_queue_stage.sv
// ifetch_queue_stage: credit-limited prefetch queue with halfword aligner; IFQ_COMPRESSED_EN enables the RVC aligner
module ifetch_queue_stage #(
  parameter int QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_compressed,
  output logic        out_illegal,
  output logic        halted
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  logic [31:0] q [QUEUE_DEPTH];
  logic [PW-1:0] rd, wr;
  logic [PW:0] cnt;
  logic [PW+1:0] used;
  logic [31:0] fa, dpc, h, instr;
  logic inflight, req_ep, epoch, halt, run, acc, push, fire, pop;
  logic wide, need2, pop_ins, comp, ill, avail, unused;
  assign unused = redirect_pc[0];
  assign run = start & !rst;
  assign used = {1'b0, cnt} + (PW+2)'(inflight);
  assign imem_req_valid = run & !halt & (used < (PW+2)'(QUEUE_DEPTH));
  assign imem_addr = run ? fa : RESET_PC;
  assign acc = imem_req_valid & imem_req_ready;
  assign push = imem_rsp_valid & inflight & (req_ep == epoch);
  assign h = q[rd];
`ifdef IFQ_COMPRESSED_EN
  logic [31:0] n;
  assign n = q[rd + 1'b1];
  assign wide = dpc[1] ? (h[17:16] == 2'b11) : (h[1:0] == 2'b11);
  assign need2 = dpc[1] & wide;
  assign pop_ins = dpc[1] | wide;
  assign instr = !dpc[1] ? (wide ? h : {16'h0, h[15:0]}) : (wide ? {n[15:0], h[31:16]} : {16'h0, h[31:16]});
  assign comp = !wide;
  assign ill = 1'b0;
`else
  assign wide = 1'b1;
  assign need2 = 1'b0;
  assign pop_ins = !dpc[1];
  assign instr = h;
  assign comp = 1'b0;
  assign ill = dpc[1] | (h[1:0] != 2'b11);
`endif
  assign avail = need2 ? (cnt >= (PW+1)'(2)) : (cnt != '0);
  assign out_valid = run & !halt & avail;
  assign fire = out_valid & out_ready & !redirect_valid;
  assign pop = fire & pop_ins;
  assign out_pc = run ? dpc : RESET_PC;
  assign out_instr = out_valid ? instr : '0;
  assign out_compressed = out_valid & comp;
  assign out_illegal = out_valid & ill;
  assign halted = run & halt;
  always_ff @(posedge clk)
    if (run && !redirect_valid && push) q[wr] <= imem_rsp_data;
  always_ff @(posedge clk) begin
    if (!run) begin
      fa <= RESET_PC;
      dpc <= RESET_PC;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      inflight <= 1'b0;
      req_ep <= 1'b0;
      epoch <= 1'b0;
      halt <= 1'b0;
    end else begin
      inflight <= acc;
      req_ep <= epoch;
      if (redirect_valid) begin
        fa <= {redirect_pc[31:2], 2'b00};
        dpc <= {redirect_pc[31:1], 1'b0};
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        epoch <= !epoch;
        halt <= 1'b0;
      end else begin
        if (acc) fa <= fa + 32'd4;
        if (push) wr <= wr + 1'b1;
        if (pop) rd <= rd + 1'b1;
        cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        if (fire) dpc <= dpc + (wide ? 32'd4 : 32'd2);
        if (fire && instr[6:0] == 7'h7F) halt <= 1'b1;
      end
    end
  end
endmodule

// File: doc/ifetch_queue_stage.md
# ifetch_queue_stage

Parametrised instruction fetch stage with a decoupled prefetch queue. It issues word-aligned requests to a synchronous instruction memory and buffers the returned words in a DEPTH-entry queue. A halfword aligner then presents one 16- or 32-bit instruction per cycle to decode over a valid/ready handshake. It supports branch redirect with in-flight squash, decode back-pressure in place of a hazard hold, and halt on opcode 7'h7F. It sits between the instruction memory and the decompressor/decode stage.

## Interface
- QUEUE_DEPTH, 4: word entries in the prefetch queue; power of two, 2..16.
- RESET_PC, 32'h0: PC loaded on reset, while start==0, and at start.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  run enable; 0 holds the stage idle at RESET_PC and flushes it.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  read data valid, exactly one cycle after an accepted request.
- imem_rsp_data  in  32  read word.
- redirect_valid  in  1  branch taken.
- redirect_pc  in  32  branch target; bit 0 is ignored.
- out_valid  out  1  instruction available.
- out_ready  in  1  decode accepts; 0 = hazard stall.
- out_pc  out  32  PC of the presented instruction.
- out_instr  out  32  raw instruction; a 16-bit instruction is zero-extended.
- out_compressed  out  1  out_instr is 16-bit.
- out_illegal  out  1  misaligned or unsupported encoding.
- halted  out  1  fetch stopped on 7'h7F.

## Operation
- Fetch address register `fa` and decode PC register `dpc`.
- Issue rule: imem_req_valid = start & !halted & !rst & (queue_count + inflight < QUEUE_DEPTH). On handshake, `fa` += 4.
- Each response is pushed into the queue tagged with an epoch bit. A response whose epoch is stale is discarded.
- Aligner, with head word H and next word N:
  - dpc[1]==0, H[1:0]==2'b11: 32-bit instruction H. Pop 1, dpc += 4.
  - dpc[1]==0, otherwise: 16-bit instruction H[15:0]. No pop, dpc += 2.
  - dpc[1]==1, H[17:16]!=2'b11: 16-bit instruction H[31:16]. Pop 1, dpc += 2.
  - dpc[1]==1, H[17:16]==2'b11: spanning instruction {N[15:0], H[31:16]}. Requires queue_count>=2. Pop 1, dpc += 4.
- out_valid is asserted only when the required words are present and the stage is not halted. Consumption happens only on out_valid & out_ready.
- Redirect has priority over everything in the same cycle:
  - flush the queue, toggle the epoch;
  - fa={redirect_pc[31:2],2'b00}, dpc={redirect_pc[31:1],1'b0};
  - clear halted;
  - any response arriving in the same or the next cycle is dropped.
- Halt: an instruction with [6:0]==7'h7F is presented normally. On its acceptance, halted=1 and requests stop. halted clears only on redirect, rst, or start==0.
- Reset, and start==0, set:
  - fa=dpc=RESET_PC, queue empty, epoch=0, halted=0;
  - all outputs 0 except out_pc=RESET_PC and imem_addr=RESET_PC.
- Empty queue: out_valid=0. Full queue including in-flight requests: no request is issued. out_ready=0 holds out_* stable.

## Timing
- Start asserted in cycle N: request in N, response in N+1, out_valid in N+2.
- Throughput: one instruction per cycle with back-to-back requests and out_ready=1.
- Redirect in cycle R: first new request in R+1, out_valid no earlier than R+3.
- A push and a pop in the same cycle keep queue_count unchanged. A push into a full queue cannot occur, because credits are counted.

## Configuration
- IFQ_COMPRESSED_EN defined: full RVC aligner as described; out_compressed is live.
- IFQ_COMPRESSED_EN undefined:
  - every word is one instruction; dpc += 4; out_compressed=0;
  - a word with [1:0]!=2'b11 is presented with out_illegal=1;
  - redirect_pc[1]==1 presents the next instruction with out_illegal=1 and no pop.

## Test plan
- Reset then start, memory {0x00A00093, 0x00B00113}: out_pc 0x0 then 0x4 in cycles N+2 and N+3, both with out_compressed=0.
- Words {0x45814501, 0x00C00193}: 16-bit 0x4501@0, 16-bit 0x4581@2, 32-bit @4.
- Spanning case, words {0x00934501, 0x4505_00A0}: 0x4501@0, then 0x00A00093@2 emitted only once both words are queued.
- out_ready=0 for 10 cycles with QUEUE_DEPTH=4: exactly 4 words fetched, out_* stable; on release, no instruction is lost or duplicated.
- Redirect to 0x102 while 3 words are queued and 1 is in flight: queue flushed, stale response dropped, next out_pc=0x102.
- Word 0x0000007F at 0x8: presented, then halted=1 and no further requests; redirect to 0x0 resumes fetch.
